mmu_ctrl: RTL and testbench
===========================

MMU_CTRL -- requirements
Module: mmu_ctrl

Interface
REQ-001 Parameter ARRAY_N, default 4: systolic array dimension, rows = columns; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 8: number of input vectors fed per job (K length); SHALL be >= 1.
REQ-003 Localparam CW = clog2(max(DEPTH, 2*ARRAY_N-2, ARRAY_N)) + 1: phase counter width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  job request; sampled only in IDLE.
REQ-007 abort_i  input  1  synchronous job cancel; valid in any state.
REQ-008 drain_ready_i  input  1  downstream accepts the output row this cycle.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 w_load_o  output  1  weight shift-in enable for the array.
REQ-011 w_row_o  output  CW  index of the weight row being loaded.
REQ-012 feed_valid_o  output  1  input vector valid into the array edge.
REQ-013 feed_idx_o  output  CW  index of the input vector being fed.
REQ-014 acc_clear_o  output  1  one-cycle accumulator clear pulse.
REQ-015 out_valid_o  output  1  output row valid toward the drain side.
REQ-016 out_row_o  output  CW  index of the output row presented.
REQ-017 done_o  output  1  one-cycle job-complete pulse.

Function
REQ-018 FSM states SHALL be IDLE, LOAD_W, FEED, FLUSH, DRAIN and DONE, with one shared phase counter cnt (CW bits).
REQ-019 IDLE -> LOAD_W on a clock edge with start_i=1, and cnt SHALL be 0 on entry to every phase.
REQ-020 LOAD_W SHALL last exactly ARRAY_N cycles: w_load_o=1, w_row_o=cnt, then -> FEED when cnt==ARRAY_N-1.
REQ-021 acc_clear_o SHALL be 1 only in the first LOAD_W cycle (cnt==0).
REQ-022 FEED SHALL last exactly DEPTH cycles: feed_valid_o=1, feed_idx_o=cnt, then -> FLUSH when cnt==DEPTH-1.
REQ-023 FLUSH SHALL last exactly 2*ARRAY_N-2 cycles (skew drain) with all enables low, then -> DRAIN.
REQ-024 DRAIN: out_valid_o=1 and out_row_o=cnt; cnt SHALL advance only on cycles with drain_ready_i=1.
REQ-025 DRAIN -> DONE on the cycle where drain_ready_i=1 and cnt==ARRAY_N-1.
REQ-026 With drain_ready_i=0, out_valid_o and out_row_o SHALL hold stable (no row dropped or repeated).
REQ-027 DONE SHALL last one cycle with done_o=1, then -> IDLE.
REQ-028 start_i outside IDLE, including in DONE, SHALL be ignored; the next job needs start_i in IDLE.
REQ-029 abort_i=1 SHALL force next state IDLE and cnt=0 from any state, SHALL take priority over every other transition, and SHALL NOT pulse done_o.
REQ-030 All outputs SHALL be Moore decodes of state and cnt (no combinational path from any input).
REQ-031 Outside their phase, w_row_o, feed_idx_o and out_row_o SHALL be 0.
REQ-032 cnt SHALL never exceed its phase terminal value; no wrap-around inside a phase.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE, cnt 0, and every output 0, independent of clk.
REQ-034 Reset deassertion mid-job SHALL NOT resume the job; the block SHALL wait in IDLE for start_i.

Verification (ARRAY_N=4, DEPTH=8)
REQ-035 Pulse start_i, drain_ready_i=1 throughout:
  - w_load_o high for cycles 1-4 after the sampling edge, with w_row_o 0..3 and acc_clear_o in cycle 1;
  - feed_valid_o high for cycles 5-12, feed_idx_o 0..7;
  - outputs idle for cycles 13-18;
  - out_valid_o high for cycles 19-22, out_row_o 0..3;
  - done_o high in cycle 23 only.
REQ-036 drain_ready_i=0 for 3 cycles at out_row_o=2: row 2 held for 4 cycles; done_o delayed by 3 cycles to cycle 26.
REQ-037 abort_i in FEED at feed_idx_o=5: busy_o=0 next cycle, all outputs 0, no done_o pulse; a following start_i runs a full job normally.
REQ-038 start_i held high continuously: jobs run back to back with exactly one IDLE cycle between done_o and the next w_load_o.
REQ-039 rst_n asserted in DRAIN at out_row_o=1: outputs 0 immediately (asynchronously); after release, busy_o stays 0 until start_i.
REQ-040 start_i pulsed during LOAD_W and during DONE: no effect; exactly one done_o pulse observed.

Source files
------------

// File: rtl/mmu_ctrl.sv
// Sequencer for an ARRAY_N x ARRAY_N systolic matrix unit.
// Runs one job: weight load, DEPTH-vector feed, skew flush, then a back-pressured row drain.
module mmu_ctrl #(
  parameter  int ARRAY_N = 4,
  parameter  int DEPTH   = 8,
  localparam int MAX_A   = (DEPTH > 2*ARRAY_N-2) ? DEPTH : 2*ARRAY_N-2,
  localparam int MAX_V   = (MAX_A > ARRAY_N) ? MAX_A : ARRAY_N,
  localparam int CW      = $clog2(MAX_V) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          drain_ready_i,
  output logic          busy_o,
  output logic          w_load_o,
  output logic [CW-1:0] w_row_o,
  output logic          feed_valid_o,
  output logic [CW-1:0] feed_idx_o,
  output logic          acc_clear_o,
  output logic          out_valid_o,
  output logic [CW-1:0] out_row_o,
  output logic          done_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CW-1:0] LOAD_LAST  = CW'(ARRAY_N - 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2*ARRAY_N - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ARRAY_N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every phase exit clears cnt, so each phase starts counting from 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_ready_i) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs decode registered state only, so they fall to 0 as soon as reset asserts.
  always_comb begin
    busy_o       = (state_q != IDLE);
    w_load_o     = (state_q == LOAD_W);
    w_row_o      = (state_q == LOAD_W) ? cnt_q : '0;
    acc_clear_o  = (state_q == LOAD_W) && (cnt_q == '0);
    feed_valid_o = (state_q == FEED);
    feed_idx_o   = (state_q == FEED) ? cnt_q : '0;
    out_valid_o  = (state_q == DRAIN);
    out_row_o    = (state_q == DRAIN) ? cnt_q : '0;
    done_o       = (state_q == DONE);
  end

endmodule

// File: tb/tb_mmu_ctrl.sv
// Directed bench for mmu_ctrl (ARRAY_N=4, DEPTH=8): cycle-by-cycle output checks
// against the hand-derived job schedule, plus abort, back-to-back, reset and stray-start cases.
module tb_mmu_ctrl;

  localparam int CW = 4;  // clog2(max(8, 6, 4)) + 1

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          drain_ready_i = 1'b1;
  logic          busy_o, w_load_o, feed_valid_o, acc_clear_o, out_valid_o, done_o;
  logic [CW-1:0] w_row_o, feed_idx_o, out_row_o;

  int n_vec  = 0;
  int n_miss = 0;

  mmu_ctrl #(.ARRAY_N(4), .DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .drain_ready_i(drain_ready_i),
    .busy_o       (busy_o),
    .w_load_o     (w_load_o),
    .w_row_o      (w_row_o),
    .feed_valid_o (feed_valid_o),
    .feed_idx_o   (feed_idx_o),
    .acc_clear_o  (acc_clear_o),
    .out_valid_o  (out_valid_o),
    .out_row_o    (out_row_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_outs();
    return {14'd0, busy_o, w_load_o, w_row_o, feed_valid_o, feed_idx_o,
            acc_clear_o, out_valid_o, out_row_o, done_o};
  endfunction

  // Schedule counted from the edge that samples start_i (cycle 1 = first LOAD_W cycle);
  // s = number of stall cycles applied while row 2 is presented.
  function automatic logic [31:0] exp_vec(input int c, input int s);
    logic          busy, wl, fv, ac, ov, dn;
    logic [CW-1:0] wr, fi, orow;
    busy = (c >= 1) && (c <= 23 + s);
    wl   = (c >= 1) && (c <= 4);
    wr   = wl ? CW'(c - 1) : '0;
    ac   = (c == 1);
    fv   = (c >= 5) && (c <= 12);
    fi   = fv ? CW'(c - 5) : '0;
    ov   = (c >= 19) && (c <= 22 + s);
    if (!ov)           orow = '0;
    else if (c < 21)   orow = CW'(c - 19);
    else if (c <= 21 + s) orow = CW'(2);
    else               orow = CW'(3);
    dn   = (c == 23 + s);
    return {14'd0, busy, wl, wr, fv, fi, ac, ov, orow, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a job and checks every cycle through a few idle cycles after done.
  task automatic run_job(input string name, input int s, input bit poke);
    int dones = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 26 + s; c++) begin
      drain_ready_i = !((c >= 21) && (c < 21 + s));
      start_i = poke && ((c == 2) || (c == 23 + s));
      chk($sformatf("%s c%0d", name, c), pack_outs(), exp_vec(c, s));
      if (done_o) dones++;
      tick();
    end
    start_i = 1'b0;
    drain_ready_i = 1'b1;
    chk({name, " done_count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    #3;
    chk("reset_outs", pack_outs(), 32'd0);
    #4 rst_n = 1'b1;
    tick();
    chk("idle_after_reset", pack_outs(), 32'd0);

    run_job("basic", 0, 1'b0);
    run_job("stall3", 3, 1'b0);

    // Abort in FEED at feed_idx 5 (cycle 10).
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("pre_abort c%0d", c), pack_outs(), exp_vec(c, 0));
      if (c < 10) tick();
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post_abort %0d", c), pack_outs(), 32'd0);
      tick();
    end
    run_job("after_abort", 0, 1'b0);

    // start_i held high: one IDLE cycle between done and the next load.
    start_i = 1'b1;
    tick();
    for (int c = 1; c <= 25; c++) begin
      if (c <= 24) chk($sformatf("b2b c%0d", c), pack_outs(), exp_vec(c, 0));
      else         chk("b2b restart", pack_outs(), exp_vec(1, 0));
      if (c < 25) tick();
    end
    start_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("b2b abort_idle", pack_outs(), 32'd0);

    // Asynchronous reset in DRAIN at out_row 1 (cycle 20).
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("pre_reset row1", pack_outs(), exp_vec(20, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", pack_outs(), 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post_reset busy %0d", c), 32'(busy_o), 32'd0);
      tick();
    end
    run_job("after_reset", 0, 1'b0);

    // Stray start pulses in LOAD_W and DONE are ignored.
    run_job("stray_start", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
